lives_hud_compositor: RTL and testbench
=======================================

Name: lives_hud_compositor

Overview:
- Parametrised lives counter and heads-up-display compositor for the arcade game.
- Tracks remaining lives, loses a life on a barrier collision, and grants extra lives.
- Enforces a frame-counted invulnerability window after each hit.
- Renders a "LIVES" label plus one heart glyph per remaining life into the pixel stream, with registered outputs, for the top-level layer mixer.

Parameters:
- MAX_LIVES, 5, maximum heart count and saturation limit (1..8).
- START_LIVES, 3, lives loaded at reset/restart (1..MAX_LIVES).
- POS_X, 80, left pixel column of the HUD region.
- POS_Y, 20, top pixel row of the HUD region.
- SCALE_LOG2, 3, log2 of pixels per glyph cell (cell = 8x8 px).
- INVULN_FRAMES, 60, frames of invulnerability after an accepted hit (1..255).
- BLINK_LOG2, 3, blink half-period = 2^BLINK_LOG2 frames.

Ports:
- i_clk  in  1  pixel clock
- i_rst_n  in  1  asynchronous active-low reset
- i_x  in  16  current pixel column
- i_y  in  16  current pixel row
- i_v_sync  in  1  vertical sync, level; a rising edge marks a frame
- i_barrier_hit  in  1  collision level; a rising edge requests a life loss
- i_extra_life  in  1  level; a rising edge requests +1 life
- i_restart  in  1  synchronous game restart, active high
- o_red  out  8  pixel red
- o_green  out  8  pixel green
- o_blue  out  8  pixel blue
- o_sprite_hit  out  1  HUD pixel opaque
- o_lives  out  4  current life count
- o_invuln  out  1  invulnerability active
- o_out_of_lives  out  1  game over, sticky

Behaviour:
- Reset (i_rst_n=0, async): lives=START_LIVES, invuln counter=0, frame counter=0, edge registers=0, all outputs 0; o_lives=START_LIVES after release.
- Edge detect: each of i_v_sync, i_barrier_hit and i_extra_life is registered once; rise = in & ~prev. Rise is detected 1 cycle after the input goes high. A held-high level produces one event only.
- Accepted hit: barrier rise && lives>0 && invuln==0 && !out_of_lives. Effects on the next edge: lives-1, invuln counter=INVULN_FRAMES.
- Rejected hits are dropped silently; they are not queued.
- Extra life rise: lives+1, saturating at MAX_LIVES. Ignored when out_of_lives=1.
- Accepted hit and extra-life rise in the same cycle: lives unchanged, invuln still loaded.
- Invuln counter: decrements by 1 on each v_sync rise while nonzero. o_invuln = (counter!=0).
- Frame counter: 8-bit, increments on every v_sync rise, wraps freely.
- o_out_of_lives: set the cycle after lives reaches 0; held until restart or reset.
- i_restart: same effect as reset, applied synchronously. Has priority over hit and extra life in the same cycle.
- Rendering geometry:
  - cx=(i_x-POS_X)>>SCALE_LOG2, cy=(i_y-POS_Y)>>SCALE_LOG2, computed only inside the region.
  - Region width: max(20, 6*MAX_LIVES) cells. Region height: 12 cells.
- Label: rows 0-4, columns 0-19, fixed 5-row "LIVES" font, palette 1.
- Hearts: rows 7-11. Heart k occupies columns 6k..6k+4. Glyph rows are 00100, 01110, 11111, 01110, 00100.
  - Heart k is drawn in palette 2 when k<lives.
  - Heart k==lives is drawn in palette 3 when invuln!=0 and frame bit BLINK_LOG2 is 1.
- Palette: 0 transparent (00,00,00), 1 grey (20,20,20), 2 red (FF,00,00), 3 yellow (FF,FF,00).
- Pixel outputs are registered: latency exactly 1 clock from i_x/i_y.
- Outside the region or on a transparent cell: RGB=0 and o_sprite_hit=0. No X values are ever driven.
- Pixel reads use the lives value registered this cycle. Count changes appear mid-frame; no frame-boundary latching.

Optional Feature:
- Macro: LIVES_HUD_EMPTY_SLOT_EN.
- Defined: heart slots k with lives<=k<MAX_LIVES (excluding a blinking slot) are drawn in palette 1 grey, and o_sprite_hit=1 on those cells.
- Undefined: those slots are transparent.

Test Plan:
- Reset release, default params -> o_lives=3, o_invuln=0, o_out_of_lives=0. Pixel at (80,20) reads RGB 20/20/20 and hit=1 one clock later.
- Pulse i_barrier_hit -> o_lives=2 and o_invuln=1. Second pulse before 60 v_sync rises -> o_lives stays 2. After 60 v_sync rises, o_invuln=0.
- Three accepted hits, each separated by 60 frames -> o_lives=0, o_out_of_lives=1 next cycle. A later i_extra_life pulse leaves o_lives=0. i_restart -> o_lives=3, o_out_of_lives=0.
- Five i_extra_life pulses from 3 -> o_lives saturates at 5. Hit and extra-life rises in the same cycle -> o_lives unchanged, o_invuln=1.
- Scan heart row cy=9, lives=2, no invuln -> red over columns 0-4 and 6-10. Columns 12-16 transparent, or grey with LIVES_HUD_EMPTY_SLOT_EN defined. Pixels outside the region give RGB=0, hit=0.
- Drive i_rst_n low mid-frame during invuln -> all outputs 0 immediately, without waiting for a clock. After release, o_lives=3 and o_invuln=0.

Source files
------------

// File: rtl/lives_hud_compositor_if.sv
// Pixel-position, game-event and pixel/status output bundle for lives_hud_compositor.
`default_nettype none

interface lives_hud_compositor_if;
  logic [15:0] i_x;
  logic [15:0] i_y;
  logic        i_v_sync;
  logic        i_barrier_hit;
  logic        i_extra_life;
  logic        i_restart;
  logic [7:0]  o_red;
  logic [7:0]  o_green;
  logic [7:0]  o_blue;
  logic        o_sprite_hit;
  logic [3:0]  o_lives;
  logic        o_invuln;
  logic        o_out_of_lives;

  modport master (
    output i_x, i_y, i_v_sync, i_barrier_hit, i_extra_life, i_restart,
    input  o_red, o_green, o_blue, o_sprite_hit, o_lives, o_invuln, o_out_of_lives
  );

  modport slave (
    input  i_x, i_y, i_v_sync, i_barrier_hit, i_extra_life, i_restart,
    output o_red, o_green, o_blue, o_sprite_hit, o_lives, o_invuln, o_out_of_lives
  );
endinterface

`default_nettype wire

// File: rtl/lives_hud_compositor.sv
// lives_hud_compositor: lives counter, hit invulnerability and "LIVES"/heart HUD overlay.
// Optional macro LIVES_HUD_EMPTY_SLOT_EN draws lost heart slots in grey.
`default_nettype none

module lives_hud_compositor #(
  parameter int MAX_LIVES     = 5,
  parameter int START_LIVES   = 3,
  parameter int POS_X         = 80,
  parameter int POS_Y         = 20,
  parameter int SCALE_LOG2    = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int BLINK_LOG2    = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  lives_hud_compositor_if.slave  hud
);

  localparam int unsigned REGION_W = (6 * MAX_LIVES > 20) ? 6 * MAX_LIVES : 20;
  localparam int unsigned REGION_H = 12;
  localparam logic [3:0]  START_Q  = 4'(START_LIVES);
  localparam logic [3:0]  MAX_Q    = 4'(MAX_LIVES);
  localparam logic [7:0]  INVULN_LD = 8'(INVULN_FRAMES);

  function automatic logic [19:0] font_row(input logic [2:0] r);
    case (r)
      3'd0:    font_row = 20'b1000_1110_1010_1110_1110;
      3'd1:    font_row = 20'b1000_0100_1010_1000_1000;
      3'd2:    font_row = 20'b1000_0100_1010_1100_1110;
      3'd3:    font_row = 20'b1000_0100_1010_1000_0010;
      3'd4:    font_row = 20'b1110_1110_0100_1110_1110;
      default: font_row = 20'b0;
    endcase
  endfunction

  function automatic logic [4:0] heart_row(input logic [2:0] r);
    case (r)
      3'd0, 3'd4: heart_row = 5'b00100;
      3'd1, 3'd3: heart_row = 5'b01110;
      3'd2:       heart_row = 5'b11111;
      default:    heart_row = 5'b00000;
    endcase
  endfunction

  logic       vs_q, hit_q, xl_q, ool_q, ool_d, spr_q;
  logic [3:0] lives_q, lives_d;
  logic [7:0] invuln_q, invuln_d, frame_q, frame_d;
  logic [7:0] red_q, green_q, blue_q;

  logic w_vs_rise, w_hit_rise, w_xl_rise, w_accept, w_grant;
  assign w_vs_rise  = hud.i_v_sync & ~vs_q;
  assign w_hit_rise = hud.i_barrier_hit & ~hit_q;
  assign w_xl_rise  = hud.i_extra_life & ~xl_q;
  assign w_accept   = w_hit_rise && (lives_q != 4'd0) && (invuln_q == 8'd0) && !ool_q;
  assign w_grant    = w_xl_rise && !ool_q;

  always_comb begin
    lives_d  = lives_q;
    invuln_d = invuln_q;
    frame_d  = frame_q;
    ool_d    = ool_q | (lives_q == 4'd0);
    // A simultaneous hit and extra life cancel in the count but still arm invulnerability.
    if (w_accept && !w_grant)
      lives_d = lives_q - 4'd1;
    else if (w_grant && !w_accept && (lives_q < MAX_Q))
      lives_d = lives_q + 4'd1;
    if (w_accept)
      invuln_d = INVULN_LD;
    else if (w_vs_rise && (invuln_q != 8'd0))
      invuln_d = invuln_q - 8'd1;
    if (w_vs_rise)
      frame_d = frame_q + 8'd1;
  end

  logic [16:0] w_dx, w_dy;
  logic [15:0] w_cx, w_cy;
  logic        w_in_region, w_slot_hit;
  logic [3:0]  w_slot;
  logic [2:0]  w_col;
  logic [4:0]  w_hrow;
  logic [19:0] w_frow;
  logic [1:0]  w_pal;

  assign w_dx = {1'b0, hud.i_x} - 17'(POS_X);
  assign w_dy = {1'b0, hud.i_y} - 17'(POS_Y);
  assign w_cx = w_dx[15:0] >> SCALE_LOG2;
  assign w_cy = w_dy[15:0] >> SCALE_LOG2;
  assign w_in_region = !w_dx[16] && !w_dy[16] &&
                       (32'(w_cx) < REGION_W) && (32'(w_cy) < REGION_H);

  always_comb begin
    w_slot_hit = 1'b0;
    w_slot     = 4'd0;
    w_col      = 3'd0;
    for (int k = 0; k < MAX_LIVES; k++) begin
      if ((w_cx >= 16'(6 * k)) && (w_cx < 16'(6 * k + 5))) begin
        w_slot_hit = 1'b1;
        w_slot     = 4'(k);
        w_col      = 3'(w_cx - 16'(6 * k));
      end
    end
  end

  always_comb begin
    w_pal  = 2'd0;
    w_frow = font_row(w_cy[2:0]);
    w_hrow = heart_row(3'(w_cy - 16'd7));
    if (w_in_region && (w_cy < 16'd5) && (w_cx < 16'd20)) begin
      w_pal = w_frow[5'd19 - w_cx[4:0]] ? 2'd1 : 2'd0;
    end else if (w_in_region && (w_cy >= 16'd7) && w_slot_hit && w_hrow[3'd4 - w_col]) begin
      if (w_slot < lives_q)
        w_pal = 2'd2;
      else if ((w_slot == lives_q) && (invuln_q != 8'd0) && frame_q[BLINK_LOG2])
        w_pal = 2'd3;
      else
`ifdef LIVES_HUD_EMPTY_SLOT_EN
        w_pal = 2'd1;
`else
        w_pal = 2'd0;
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      {vs_q, hit_q, xl_q, ool_q, spr_q} <= 5'b0;
      lives_q  <= START_Q;
      invuln_q <= 8'd0;
      frame_q  <= 8'd0;
      {red_q, green_q, blue_q} <= 24'h0;
    end else if (hud.i_restart) begin
      {vs_q, hit_q, xl_q, ool_q, spr_q} <= 5'b0;
      lives_q  <= START_Q;
      invuln_q <= 8'd0;
      frame_q  <= 8'd0;
      {red_q, green_q, blue_q} <= 24'h0;
    end else begin
      vs_q     <= hud.i_v_sync;
      hit_q    <= hud.i_barrier_hit;
      xl_q     <= hud.i_extra_life;
      ool_q    <= ool_d;
      lives_q  <= lives_d;
      invuln_q <= invuln_d;
      frame_q  <= frame_d;
      spr_q    <= (w_pal != 2'd0);
      case (w_pal)
        2'd1:    {red_q, green_q, blue_q} <= 24'h202020;
        2'd2:    {red_q, green_q, blue_q} <= 24'hFF0000;
        2'd3:    {red_q, green_q, blue_q} <= 24'hFFFF00;
        default: {red_q, green_q, blue_q} <= 24'h000000;
      endcase
    end
  end

  // The count reads 0 while held in reset and START_LIVES as soon as reset releases.
  assign hud.o_lives        = i_rst_n ? lives_q : 4'd0;
  assign hud.o_invuln       = (invuln_q != 8'd0);
  assign hud.o_out_of_lives = ool_q;
  assign hud.o_red          = red_q;
  assign hud.o_green        = green_q;
  assign hud.o_blue         = blue_q;
  assign hud.o_sprite_hit   = spr_q;

endmodule

`default_nettype wire

// File: tb/tb_lives_hud_compositor.sv
// Self-checking bench for lives_hud_compositor: vector table, directed sequences, random vs reference model.
`default_nettype none

module tb_lives_hud_compositor;
  localparam int MAXL = 5, STARTL = 3, PX = 80, PY = 20, SL = 3, INV = 60, BL = 3;
  localparam int RW = (6 * MAXL > 20) ? 6 * MAXL : 20;
`ifdef LIVES_HUD_EMPTY_SLOT_EN
  localparam int EMPTY_PAL = 1;
`else
  localparam int EMPTY_PAL = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lives_hud_compositor_if hud ();

  lives_hud_compositor #(
    .MAX_LIVES(MAXL), .START_LIVES(STARTL), .POS_X(PX), .POS_Y(PY),
    .SCALE_LOG2(SL), .INVULN_FRAMES(INV), .BLINK_LOG2(BL)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .hud    (hud)
  );

  int n_err = 0;
  int n_chk = 0;

  int m_lives, m_inv, m_frame, e_rgb;
  bit m_ool, m_pvs, m_phit, m_pxl, e_hit;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int pal_rgb(input int p);
    case (p)
      1:       return 32'h202020;
      2:       return 32'hFF0000;
      3:       return 32'hFFFF00;
      default: return 0;
    endcase
  endfunction

  function automatic int ref_pal(input int x, input int y, input int lv, input int inv, input int fr);
    int cx, cy, k, c;
    string s;
    if (x < PX || y < PY) return 0;
    cx = (x - PX) / (1 << SL);
    cy = (y - PY) / (1 << SL);
    if (cx >= RW || cy >= 12) return 0;
    if (cy < 5) begin
      if (cx >= 20) return 0;
      case (cy)
        0: s = "10001110101011101110";
        1: s = "10000100101010001000";
        2: s = "10000100101011001110";
        3: s = "10000100101010000010";
        default: s = "11101110010011101110";
      endcase
      return (s[cx] == "1") ? 1 : 0;
    end
    if (cy < 7) return 0;
    k = cx / 6;
    c = cx % 6;
    if (k >= MAXL || c == 5) return 0;
    case (cy - 7)
      0, 4: s = "00100";
      1, 3: s = "01110";
      default: s = "11111";
    endcase
    if (s[c] != "1") return 0;
    if (k < lv) return 2;
    if (k == lv && inv > 0 && ((fr >> BL) % 2) == 1) return 3;
    return EMPTY_PAL;
  endfunction

  task automatic model_reset();
    m_lives = STARTL; m_inv = 0; m_frame = 0; m_ool = 0;
    m_pvs = 0; m_phit = 0; m_pxl = 0; e_rgb = 0; e_hit = 0;
  endtask

  // One clock: advance the reference model on the edge, then compare every output.
  task automatic step();
    bit vr, hr, xr, acc, ext;
    int p;
    @(posedge clk);
    if (hud.i_restart) begin
      model_reset();
    end else begin
      p = ref_pal(int'(hud.i_x), int'(hud.i_y), m_lives, m_inv, m_frame);
      e_rgb = pal_rgb(p);
      e_hit = (p != 0);
      vr = hud.i_v_sync && !m_pvs;
      hr = hud.i_barrier_hit && !m_phit;
      xr = hud.i_extra_life && !m_pxl;
      acc = hr && m_lives > 0 && m_inv == 0 && !m_ool;
      ext = xr && !m_ool;
      if (m_lives == 0) m_ool = 1;
      if (acc && !ext) m_lives--;
      else if (ext && !acc && m_lives < MAXL) m_lives++;
      if (acc) m_inv = INV;
      else if (vr && m_inv > 0) m_inv--;
      if (vr) m_frame = (m_frame + 1) % 256;
      m_pvs = hud.i_v_sync; m_phit = hud.i_barrier_hit; m_pxl = hud.i_extra_life;
    end
    #1;
    chk("lives", int'(hud.o_lives), m_lives);
    chk("invuln", int'(hud.o_invuln), int'(m_inv != 0));
    chk("out_of_lives", int'(hud.o_out_of_lives), int'(m_ool));
    chk("rgb", int'({hud.o_red, hud.o_green, hud.o_blue}), e_rgb);
    chk("sprite_hit", int'(hud.o_sprite_hit), int'(e_hit));
  endtask

  task automatic pulse_hit();   hud.i_barrier_hit = 1; step(); hud.i_barrier_hit = 0; step(); endtask
  task automatic pulse_xl();    hud.i_extra_life = 1;  step(); hud.i_extra_life = 0;  step(); endtask
  task automatic pulse_rs();    hud.i_restart = 1;     step(); hud.i_restart = 0;     step(); endtask
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      hud.i_v_sync = 1; step(); hud.i_v_sync = 0; step();
    end
  endtask

  typedef struct {
    int x; int y; int rgb; int hit;
  } vec_t;
  vec_t vecs[15];

  initial begin
    vecs[0]  = '{80, 20, 32'h202020, 1};
    vecs[1]  = '{79, 20, 0, 0};
    vecs[2]  = '{80, 19, 0, 0};
    vecs[3]  = '{88, 20, 0, 0};
    vecs[4]  = '{112, 20, 32'h202020, 1};
    vecs[5]  = '{87, 52, 32'h202020, 1};
    vecs[6]  = '{80, 92, 32'hFF0000, 1};
    vecs[7]  = '{176, 92, 32'hFF0000, 1};
    vecs[8]  = '{224, 92, (EMPTY_PAL != 0) ? 32'h202020 : 0, EMPTY_PAL};
    vecs[9]  = '{96, 76, 32'hFF0000, 1};
    vecs[10] = '{80, 76, 0, 0};
    vecs[11] = '{319, 92, 0, 0};
    vecs[12] = '{320, 92, 0, 0};
    vecs[13] = '{80, 116, 0, 0};
    vecs[14] = '{80, 60, 0, 0};

    hud.i_x = 0; hud.i_y = 0; hud.i_v_sync = 0; hud.i_barrier_hit = 0;
    hud.i_extra_life = 0; hud.i_restart = 0;
    model_reset();

    repeat (2) @(posedge clk);
    #2;
    chk("in_reset_lives", int'(hud.o_lives), 0);
    chk("in_reset_rgb", int'({hud.o_red, hud.o_green, hud.o_blue, hud.o_sprite_hit}), 0);
    rst_n = 1;
    #1;
    chk("rst_lives", int'(hud.o_lives), STARTL);
    chk("rst_invuln", int'(hud.o_invuln), 0);
    chk("rst_ool", int'(hud.o_out_of_lives), 0);

    for (int i = 0; i < 15; i++) begin
      hud.i_x = 16'(vecs[i].x);
      hud.i_y = 16'(vecs[i].y);
      step();
      chk($sformatf("vec%0d_rgb", i), int'({hud.o_red, hud.o_green, hud.o_blue}), vecs[i].rgb);
      chk($sformatf("vec%0d_hit", i), int'(hud.o_sprite_hit), vecs[i].hit);
    end
    hud.i_x = 0; hud.i_y = 0;

    pulse_hit();
    chk("hit1_lives", int'(hud.o_lives), 2);
    chk("hit1_invuln", int'(hud.o_invuln), 1);
    pulse_hit();
    chk("hit_rejected", int'(hud.o_lives), 2);
    frames(59);
    chk("invuln_59", int'(hud.o_invuln), 1);
    frames(1);
    chk("invuln_60", int'(hud.o_invuln), 0);

    pulse_hit(); frames(60);
    pulse_hit(); frames(60);
    hud.i_barrier_hit = 1; step();
    chk("lives_zero", int'(hud.o_lives), 0);
    hud.i_barrier_hit = 0; step();
    chk("ool_set", int'(hud.o_out_of_lives), 1);
    pulse_xl();
    chk("xl_after_over", int'(hud.o_lives), 0);
    pulse_rs();
    chk("restart_lives", int'(hud.o_lives), STARTL);
    chk("restart_ool", int'(hud.o_out_of_lives), 0);

    for (int i = 0; i < 5; i++) pulse_xl();
    chk("xl_saturate", int'(hud.o_lives), MAXL);
    hud.i_barrier_hit = 1; hud.i_extra_life = 1; step();
    hud.i_barrier_hit = 0; hud.i_extra_life = 0; step();
    chk("both_lives", int'(hud.o_lives), MAXL);
    chk("both_invuln", int'(hud.o_invuln), 1);

    pulse_rs(); pulse_hit(); frames(60);
    hud.i_y = 16'(PY + 9 * 8);
    for (int c = 0; c < 17; c++) begin
      int ex;
      hud.i_x = 16'(PX + c * 8 + 3);
      step();
      ex = (c % 6 == 5) ? 0 : (c / 6 < 2) ? 32'hFF0000 : (EMPTY_PAL != 0) ? 32'h202020 : 0;
      chk($sformatf("scan_c%0d", c), int'({hud.o_red, hud.o_green, hud.o_blue}), ex);
    end

    pulse_rs(); pulse_hit(); frames(3);
    hud.i_x = 80; hud.i_y = 92;
    step();
    #2;
    rst_n = 0;
    #1;
    chk("async_rgb", int'({hud.o_red, hud.o_green, hud.o_blue}), 0);
    chk("async_flags", int'({hud.o_sprite_hit, hud.o_invuln, hud.o_out_of_lives}), 0);
    chk("async_lives", int'(hud.o_lives), 0);
    model_reset();
    #1;
    rst_n = 1;
    #1;
    chk("post_rst_lives", int'(hud.o_lives), STARTL);
    chk("post_rst_invuln", int'(hud.o_invuln), 0);

    for (int i = 0; i < 3000; i++) begin
      hud.i_x = 16'(60 + $urandom_range(0, 280));
      hud.i_y = 16'(10 + $urandom_range(0, 120));
      hud.i_v_sync      = ($urandom_range(0, 3) == 0);
      hud.i_barrier_hit = ($urandom_range(0, 40) == 0);
      hud.i_extra_life  = ($urandom_range(0, 60) == 0);
      hud.i_restart     = ($urandom_range(0, 400) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

`default_nettype wire
